// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/flush controller.
package pipe_hazard_ctrl_pkg;

    // rd is held at a fixed width in the scoreboard, so REG_AW must not exceed SB_RD_W.
    localparam int unsigned SB_RD_W = 8;
    localparam int unsigned FWD_RF  = 0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               wen;
        logic               is_load;
    } sb_entry_t;

    function automatic int unsigned fsel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// DECO-side hazard inputs and pipeline control outputs of pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned FSEL_W = fsel_w(DEPTH);

    logic              i_id_valid;
    logic [REG_AW-1:0] i_id_rs1;
    logic [REG_AW-1:0] i_id_rs2;
    logic              i_id_rs1_used;
    logic              i_id_rs2_used;
    logic [REG_AW-1:0] i_id_rd;
    logic              i_id_wen;
    logic              i_id_is_load;
    logic              i_id_br_taken;
    logic              i_ext_hold;
    logic              o_pc_en;
    logic              o_fd_en;
    logic              o_fd_flush;
    logic              o_de_bubble;
    logic              o_pipe_en;
    logic [FSEL_W-1:0] o_fwd_a_sel;
    logic [FSEL_W-1:0] o_fwd_b_sel;
    logic [CNT_W-1:0]  o_stall_cnt;
    logic [CNT_W-1:0]  o_flush_cnt;

    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_wen, i_id_is_load, i_id_br_taken, i_ext_hold,
        input  o_pc_en, o_fd_en, o_fd_flush, o_de_bubble, o_pipe_en,
               o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_wen, i_id_is_load, i_id_br_taken, i_ext_hold,
        output o_pc_en, o_fd_en, o_fd_flush, o_de_bubble, o_pipe_en,
               o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
    );

endinterface

// File: rtl/hz_sat_counter.sv
// Saturating event counter; increments on i_inc unless held, never wraps.
module hz_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_hold,
    output logic [CNT_W-1:0] o_q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_inc && !i_hold && (r_q != '1)) begin
            r_q <= r_q + CNT_W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller: shadow scoreboard of in-flight writers after DECO, driving
// forwarding selects, load-use/RAW stalls, branch flushes and global hold.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned FWD_EN    = 1,
    parameter int unsigned ZERO_HARD = 0,
    parameter int unsigned CNT_W     = 16
) (
    input logic               i_clk,
    input logic               i_rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int unsigned FSEL_W = fsel_w(DEPTH);

    sb_entry_t         r_sb [1:DEPTH];
    logic              r_run;
    sb_entry_t         w_new;
    logic [DEPTH:1]    w_match_a;
    logic [DEPTH:1]    w_match_b;
    logic              w_zero_a;
    logic              w_zero_b;
    logic              w_raw;
    logic              w_hazard;
    logic [FSEL_W-1:0] w_sel_a;
    logic [FSEL_W-1:0] w_sel_b;
    logic              w_stall_inc;
    logic              w_flush_inc;
    logic              w_cnt_hold;

    always_comb begin
        w_new = '{valid: hz.i_id_valid, rd: SB_RD_W'(hz.i_id_rd),
                  wen: hz.i_id_wen, is_load: hz.i_id_is_load};
        w_zero_a  = (ZERO_HARD != 0) && (hz.i_id_rs1 == REG_AW'(0));
        w_zero_b  = (ZERO_HARD != 0) && (hz.i_id_rs2 == REG_AW'(0));
        w_match_a = '0;
        w_match_b = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            w_match_a[k] = r_sb[k].valid && r_sb[k].wen && hz.i_id_rs1_used && !w_zero_a
                           && (r_sb[k].rd == SB_RD_W'(hz.i_id_rs1));
            w_match_b[k] = r_sb[k].valid && r_sb[k].wen && hz.i_id_rs2_used && !w_zero_b
                           && (r_sb[k].rd == SB_RD_W'(hz.i_id_rs2));
        end

        if (FWD_EN != 0) begin
            w_raw = r_sb[1].is_load && (w_match_a[1] || w_match_b[1]);
        end else begin
            w_raw = |{w_match_a, w_match_b};
        end
        w_hazard = w_raw && hz.i_id_valid;

        // Walk oldest to youngest so the youngest match is the one left standing.
        w_sel_a = FSEL_W'(FWD_RF);
        w_sel_b = FSEL_W'(FWD_RF);
        if (FWD_EN != 0) begin
            for (int unsigned k = DEPTH; k >= 1; k--) begin
                if (w_match_a[k] && !(k == 1 && r_sb[k].is_load)) w_sel_a = FSEL_W'(k);
                if (w_match_b[k] && !(k == 1 && r_sb[k].is_load)) w_sel_b = FSEL_W'(k);
            end
        end

        hz.o_pc_en     = 1'b0;
        hz.o_fd_en     = 1'b0;
        hz.o_fd_flush  = 1'b0;
        hz.o_de_bubble = 1'b0;
        hz.o_pipe_en   = 1'b0;
        hz.o_fwd_a_sel = r_run ? w_sel_a : FSEL_W'(FWD_RF);
        hz.o_fwd_b_sel = r_run ? w_sel_b : FSEL_W'(FWD_RF);
        if (!r_run) begin
            hz.o_fd_flush  = 1'b1;
            hz.o_de_bubble = 1'b1;
        end else if (hz.i_ext_hold) begin
            hz.o_pc_en = 1'b0;
        end else if (w_hazard) begin
            // Branch operands are not valid yet, so a taken branch waits out the stall.
            hz.o_de_bubble = 1'b1;
            hz.o_pipe_en   = 1'b1;
        end else if (hz.i_id_br_taken) begin
            hz.o_pc_en    = 1'b1;
            hz.o_fd_en    = 1'b1;
            hz.o_fd_flush = 1'b1;
            hz.o_pipe_en  = 1'b1;
        end else begin
            hz.o_pc_en   = 1'b1;
            hz.o_fd_en   = 1'b1;
            hz.o_pipe_en = 1'b1;
        end

        w_cnt_hold  = !r_run || hz.i_ext_hold;
        w_stall_inc = w_hazard;
        w_flush_inc = !w_hazard && hz.i_id_br_taken;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            if (r_run && !hz.i_ext_hold) begin
                for (int unsigned k = DEPTH; k >= 2; k--) begin
                    r_sb[k] <= r_sb[k-1];
                end
                r_sb[1] <= w_hazard ? sb_entry_t'('0) : w_new;
            end
        end
    end

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_inc  (w_stall_inc),
        .i_hold (w_cnt_hold),
        .o_q    (hz.o_stall_cnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_inc  (w_flush_inc),
        .i_hold (w_cnt_hold),
        .o_q    (hz.o_flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three parameterisations share one stimulus stream.
module tb_pipe_hazard_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(4), .DEPTH(3), .CNT_W(16)) if_a ();
    pipe_hazard_ctrl_if #(.REG_AW(4), .DEPTH(3), .CNT_W(16)) if_b ();
    pipe_hazard_ctrl_if #(.REG_AW(4), .DEPTH(3), .CNT_W(2))  if_c ();

    pipe_hazard_ctrl #(.REG_AW(4), .DEPTH(3), .FWD_EN(1), .ZERO_HARD(0), .CNT_W(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .hz(if_a)
    );
    pipe_hazard_ctrl #(.REG_AW(4), .DEPTH(3), .FWD_EN(0), .ZERO_HARD(0), .CNT_W(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .hz(if_b)
    );
    pipe_hazard_ctrl #(.REG_AW(4), .DEPTH(3), .FWD_EN(1), .ZERO_HARD(1), .CNT_W(2)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .hz(if_c)
    );

    typedef struct packed {
        logic v; logic [3:0] rd; logic wen; logic ld;
        logic [3:0] rs1; logic u1; logic [3:0] rs2; logic u2; logic br; logic hold;
    } stim_t;

    typedef struct {
        int id; string tag;
        bit pc; bit fd; bit fl; bit bub; bit pipe; bit chk_sel;
        int fa; int fb; int sc; int fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic stim_t mk(input int v, input int rd, input int wen, input int ld,
                                 input int rs1, input int u1, input int rs2, input int u2,
                                 input int br, input int hold);
        stim_t s;
        s.v = 1'(v); s.rd = 4'(rd); s.wen = 1'(wen); s.ld = 1'(ld);
        s.rs1 = 4'(rs1); s.u1 = 1'(u1); s.rs2 = 4'(rs2); s.u2 = 1'(u2);
        s.br = 1'(br); s.hold = 1'(hold);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        if_a.i_id_valid = s.v; if_a.i_id_rd = s.rd; if_a.i_id_wen = s.wen;
        if_a.i_id_is_load = s.ld; if_a.i_id_rs1 = s.rs1; if_a.i_id_rs1_used = s.u1;
        if_a.i_id_rs2 = s.rs2; if_a.i_id_rs2_used = s.u2; if_a.i_id_br_taken = s.br;
        if_a.i_ext_hold = s.hold;
        if_b.i_id_valid = s.v; if_b.i_id_rd = s.rd; if_b.i_id_wen = s.wen;
        if_b.i_id_is_load = s.ld; if_b.i_id_rs1 = s.rs1; if_b.i_id_rs1_used = s.u1;
        if_b.i_id_rs2 = s.rs2; if_b.i_id_rs2_used = s.u2; if_b.i_id_br_taken = s.br;
        if_b.i_ext_hold = s.hold;
        if_c.i_id_valid = s.v; if_c.i_id_rd = s.rd; if_c.i_id_wen = s.wen;
        if_c.i_id_is_load = s.ld; if_c.i_id_rs1 = s.rs1; if_c.i_id_rs1_used = s.u1;
        if_c.i_id_rs2 = s.rs2; if_c.i_id_rs2_used = s.u2; if_c.i_id_br_taken = s.br;
        if_c.i_ext_hold = s.hold;
    endtask

    task automatic push(input int id, input string tag, input bit pc, input bit fd,
                        input bit fl, input bit bub, input bit pipe, input bit chk,
                        input int fa, input int fb, input int sc, input int fc);
        exp_t e;
        e.id = id; e.tag = tag; e.pc = pc; e.fd = fd; e.fl = fl; e.bub = bub;
        e.pipe = pipe; e.chk_sel = chk; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
        sb_q.push_back(e);
    endtask

    task automatic ex_rst(input int id, input string tag);
        push(id, tag, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    endtask
    task automatic ex_norm(input int id, input string tag, input int fa, input int fb,
                           input int sc, input int fc);
        push(id, tag, 1, 1, 0, 0, 1, 1, fa, fb, sc, fc);
    endtask
    task automatic ex_stall(input int id, input string tag, input int sc, input int fc);
        push(id, tag, 0, 0, 0, 1, 1, 0, 0, 0, sc, fc);
    endtask
    task automatic ex_br(input int id, input string tag, input int fa, input int fb,
                         input int sc, input int fc);
        push(id, tag, 1, 1, 1, 0, 1, 1, fa, fb, sc, fc);
    endtask
    task automatic ex_hold(input int id, input string tag, input int sc, input int fc);
        push(id, tag, 0, 0, 0, 0, 0, 0, 0, 0, sc, fc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int id);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        ex_rst(id, "mid_reset");
        tick();
        rst_n = 1'b1;
        ex_rst(id, "reset_release");
        tick();
    endtask

    // Monitor: outputs are valid every cycle; drain all expectations due this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic a_pc, a_fd, a_fl, a_bub, a_pipe;
        int   a_fa, a_fb, a_sc, a_fc;
        bit   ok;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.id)
                0: begin
                    a_pc = if_a.o_pc_en; a_fd = if_a.o_fd_en; a_fl = if_a.o_fd_flush;
                    a_bub = if_a.o_de_bubble; a_pipe = if_a.o_pipe_en;
                    a_fa = int'(if_a.o_fwd_a_sel); a_fb = int'(if_a.o_fwd_b_sel);
                    a_sc = int'(if_a.o_stall_cnt); a_fc = int'(if_a.o_flush_cnt);
                end
                1: begin
                    a_pc = if_b.o_pc_en; a_fd = if_b.o_fd_en; a_fl = if_b.o_fd_flush;
                    a_bub = if_b.o_de_bubble; a_pipe = if_b.o_pipe_en;
                    a_fa = int'(if_b.o_fwd_a_sel); a_fb = int'(if_b.o_fwd_b_sel);
                    a_sc = int'(if_b.o_stall_cnt); a_fc = int'(if_b.o_flush_cnt);
                end
                default: begin
                    a_pc = if_c.o_pc_en; a_fd = if_c.o_fd_en; a_fl = if_c.o_fd_flush;
                    a_bub = if_c.o_de_bubble; a_pipe = if_c.o_pipe_en;
                    a_fa = int'(if_c.o_fwd_a_sel); a_fb = int'(if_c.o_fwd_b_sel);
                    a_sc = int'(if_c.o_stall_cnt); a_fc = int'(if_c.o_flush_cnt);
                end
            endcase
            ok = (a_pc === e.pc) && (a_fd === e.fd) && (a_fl === e.fl) && (a_bub === e.bub)
                 && (a_pipe === e.pipe) && (a_sc == e.sc) && (a_fc == e.fc)
                 && (!e.chk_sel || ((a_fa == e.fa) && (a_fb == e.fb)));
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL dut%0d %s: got pc=%b fd=%b fl=%b bub=%b pipe=%b a=%0d b=%0d st=%0d fl=%0d; want pc=%b fd=%b fl=%b bub=%b pipe=%b a=%0d b=%0d (sel chk %0b) st=%0d fl=%0d",
                         e.id, e.tag, a_pc, a_fd, a_fl, a_bub, a_pipe, a_fa, a_fb, a_sc, a_fc,
                         e.pc, e.fd, e.fl, e.bub, e.pipe, e.fa, e.fb, e.chk_sel, e.sc, e.fc);
            end
        end
    end

    initial begin
        stim_t nop;
        stim_t rd_r5;
        int    s0;
        int    s1;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held 3 cycles, then release: one more !run cycle, then running.
        drive(nop);
        tick();
        for (int i = 0; i < 3; i++) begin
            ex_rst(0, "reset_a"); ex_rst(1, "reset_b"); ex_rst(2, "reset_c");
            tick();
        end
        rst_n = 1'b1;
        ex_rst(0, "first_cycle");
        tick();
        ex_norm(0, "second_cycle_a", 0, 0, 0, 0);
        ex_norm(1, "second_cycle_b", 0, 0, 0, 0);
        ex_norm(2, "second_cycle_c", 0, 0, 0, 0);
        tick();

        // ALU forwarding chain.
        drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0)); ex_norm(0, "add_r3", 0, 0, 0, 0); tick();
        drive(mk(1, 4, 1, 0, 3, 1, 0, 0, 0, 0)); ex_norm(0, "sub_fwd1", 1, 0, 0, 0); tick();
        drive(mk(1, 0, 0, 0, 4, 1, 3, 1, 0, 0)); ex_norm(0, "fwd_1_2", 1, 2, 0, 0); tick();
        drive(mk(1, 0, 0, 0, 3, 1, 3, 0, 0, 0)); ex_norm(0, "fwd3_unused", 3, 0, 0, 0); tick();
        drive(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0)); ex_norm(0, "add_r7", 0, 0, 0, 0); tick();
        drive(mk(1, 7, 1, 0, 7, 1, 0, 0, 0, 0)); ex_norm(0, "add_r7_again", 1, 0, 0, 0); tick();
        drive(mk(1, 0, 0, 0, 7, 1, 7, 1, 0, 0)); ex_norm(0, "youngest_wins", 1, 1, 0, 0); tick();
        drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); ex_norm(0, "write_r0", 0, 0, 0, 0); tick();
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex_norm(0, "r0_fwd", 1, 0, 0, 0); tick();

        // Load-use: exactly one bubble, then forward from MEM.
        do_reset(0);
        rd_r5 = mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 0);
        drive(mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 0)); ex_norm(0, "load_r5", 0, 0, 0, 0); tick();
        drive(rd_r5); ex_stall(0, "load_use_stall", 0, 0); tick();
        drive(rd_r5); ex_norm(0, "load_use_fwd2", 2, 0, 1, 0); tick();
        drive(nop); ex_norm(0, "after_load_use", 0, 0, 1, 0); tick();

        // Branch under load-use, then hold during the flush freezes everything.
        do_reset(0);
        drive(mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 0)); ex_norm(0, "load_r5_b", 0, 0, 0, 0); tick();
        drive(mk(1, 0, 0, 0, 5, 1, 0, 0, 1, 0)); ex_stall(0, "br_stall", 0, 0); tick();
        drive(mk(1, 0, 0, 0, 5, 1, 0, 0, 1, 0)); ex_br(0, "br_flush", 2, 0, 1, 0); tick();
        drive(mk(1, 0, 0, 0, 5, 1, 0, 0, 1, 1)); ex_hold(0, "hold_1", 1, 1); tick();
        drive(mk(1, 0, 0, 0, 5, 1, 0, 0, 1, 1)); ex_hold(0, "hold_2", 1, 1); tick();
        drive(mk(1, 0, 0, 0, 5, 1, 0, 0, 1, 0)); ex_br(0, "sb_frozen", 3, 0, 1, 1); tick();
        drive(nop); ex_norm(0, "flush_cnt2", 0, 0, 1, 2); tick();

        // No forwarding: reader waits until the writer leaves WB.
        do_reset(1);
        drive(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0)); ex_norm(1, "add_r2", 0, 0, 0, 0); tick();
        drive(mk(1, 0, 0, 0, 0, 0, 2, 1, 0, 0)); ex_stall(1, "nofwd_stall1", 0, 0); tick();
        ex_stall(1, "nofwd_stall2", 1, 0); tick();
        ex_stall(1, "nofwd_stall3", 2, 0); tick();
        ex_norm(1, "nofwd_release", 0, 0, 3, 0); tick();
        drive(nop); ex_norm(1, "nofwd_cnt", 0, 0, 3, 0); tick();

        // Hard-wired r0 and 2-bit saturating stall counter.
        do_reset(2);
        drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); ex_norm(2, "write_r0", 0, 0, 0, 0); tick();
        drive(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0)); ex_norm(2, "read_r0", 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            s0 = (i < 3) ? i : 3;
            s1 = (i + 1 < 3) ? i + 1 : 3;
            drive(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0)); ex_norm(2, "sat_load", 0, 0, s0, 0);
            tick();
            drive(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0)); ex_stall(2, "sat_stall", s0, 0); tick();
            ex_norm(2, "sat_fwd2", 2, 0, s1, 0); tick();
        end
        drive(nop); ex_norm(2, "sat_final", 0, 0, 3, 0); tick();

        tick();
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: stimulus did not complete, want completion before 100000");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
